// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_reader
// Function : Scans sand-cell VRAM, generates VGA timing and drives colour/sync.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_reader #(
    parameter int          ACTIVE_COLUMNS = 640,
    parameter int          ACTIVE_ROWS    = 480,
    parameter int          H_FRONT_PORCH  = 16,
    parameter int          H_SYNC_PULSE   = 96,
    parameter int          H_BACK_PORCH   = 48,
    parameter int          V_FRONT_PORCH  = 10,
    parameter int          V_SYNC_PULSE   = 2,
    parameter int          V_BACK_PORCH   = 33,
    parameter int          CLK_DIV        = 4,
    parameter int          ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
    parameter int          DATA_WIDTH     = 1,
    parameter logic [11:0] SAND_RGB       = 12'hFC0,
    parameter logic [11:0] BG_RGB         = 12'h000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] vram_rd_data_i,
    output logic [ADDR_WIDTH-1:0] vram_rd_address_o,
    output logic [11:0]           rgb_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  vblank_o,
    output logic                  vblank_start_o
);

    localparam int C_H_TOTAL = ACTIVE_COLUMNS + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int C_V_TOTAL = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int C_HW      = $clog2(C_H_TOTAL);
    localparam int C_VW      = $clog2(C_V_TOTAL);
    localparam int C_DW      = $clog2(CLK_DIV);

    localparam logic [C_DW-1:0] C_DIV_LAST   = C_DW'(CLK_DIV - 1);
    localparam logic [C_HW-1:0] C_H_LAST     = C_HW'(C_H_TOTAL - 1);
    localparam logic [C_HW-1:0] C_H_ACT      = C_HW'(ACTIVE_COLUMNS);
    localparam logic [C_HW-1:0] C_H_ACT_LAST = C_HW'(ACTIVE_COLUMNS - 1);
    localparam logic [C_HW-1:0] C_HS_START   = C_HW'(ACTIVE_COLUMNS + H_FRONT_PORCH);
    localparam logic [C_HW-1:0] C_HS_END     = C_HW'(ACTIVE_COLUMNS + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [C_VW-1:0] C_V_LAST     = C_VW'(C_V_TOTAL - 1);
    localparam logic [C_VW-1:0] C_V_ACT      = C_VW'(ACTIVE_ROWS);
    localparam logic [C_VW-1:0] C_V_ACT_LAST = C_VW'(ACTIVE_ROWS - 1);
    localparam logic [C_VW-1:0] C_VS_START   = C_VW'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [C_VW-1:0] C_VS_END     = C_VW'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE);

    logic [C_DW-1:0]       div_q;
    logic [C_HW-1:0]       h_q, h_d;
    logic [C_VW-1:0]       v_q, v_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [11:0]           rgb_q, rgb_d;
    logic                  hsync_q, vsync_q, vblank_start_q;
    logic                  w_tick, w_h_wrap, w_active, w_last_pixel, w_vblank_entry;

    always_comb begin
        w_tick         = (div_q == C_DIV_LAST);
        w_h_wrap       = (h_q == C_H_LAST);
        w_active       = (h_q < C_H_ACT) && (v_q < C_V_ACT);
        w_last_pixel   = (h_q == C_H_ACT_LAST) && (v_q == C_V_ACT_LAST);
        w_vblank_entry = w_tick && w_h_wrap && (v_q == C_V_ACT_LAST);

        h_d = w_h_wrap ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (w_h_wrap) begin
            v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
        end

        // Address tracks v*ACTIVE_COLUMNS+h through the active area and parks in blanking
        addr_d = addr_q;
        if ((h_d == '0) && (v_d == '0)) begin
            addr_d = '0;
        end else if (w_active && !w_last_pixel) begin
            addr_d = addr_q + 1'b1;
        end

        rgb_d = 12'h000;
        if (w_active) begin
            rgb_d = (vram_rd_data_i != '0) ? SAND_RGB : BG_RGB;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q          <= '0;
            h_q            <= '0;
            v_q            <= '0;
            addr_q         <= '0;
            rgb_q          <= 12'h000;
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
            vblank_start_q <= 1'b0;
        end else begin
            div_q          <= w_tick ? '0 : div_q + 1'b1;
            vblank_start_q <= w_vblank_entry;
            if (w_tick) begin
                h_q     <= h_d;
                v_q     <= v_d;
                addr_q  <= addr_d;
                // Colour and sync come from the pixel just left, so they stay mutually aligned
                rgb_q   <= rgb_d;
                hsync_q <= !((h_q >= C_HS_START) && (h_q < C_HS_END));
                vsync_q <= !((v_q >= C_VS_START) && (v_q < C_VS_END));
            end
        end
    end

    assign vram_rd_address_o = addr_q;
    assign rgb_o             = rgb_q;
    assign hsync_o           = hsync_q;
    assign vsync_o           = vsync_q;
    assign vblank_o          = (v_q >= C_V_ACT);
    assign vblank_start_o    = vblank_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_reader
// Function : Randomised self-checking bench against a pixel-count timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_reader;

    localparam int AC    = 16;
    localparam int AR    = 8;
    localparam int HFP   = 2;
    localparam int HSP   = 3;
    localparam int HBP   = 3;
    localparam int VFP   = 2;
    localparam int VSP   = 1;
    localparam int VBP   = 2;
    localparam int DIV   = 4;
    localparam int HT    = AC + HFP + HSP + HBP;
    localparam int VT    = AR + VFP + VSP + VBP;
    localparam int FRAME = HT * VT;
    localparam int AW    = $clog2(AC * AR);
    localparam logic [11:0] SAND = 12'hFC0;
    localparam logic [11:0] BG   = 12'h000;

    logic          clk_i   = 1'b0;
    logic          reset_i = 1'b0;
    logic [0:0]    vram_rd_data_i = 1'b0;
    logic [AW-1:0] vram_rd_address_o;
    logic [11:0]   rgb_o;
    logic          hsync_o, vsync_o, vblank_o, vblank_start_o;

    bit mem [0:AC*AR-1];
    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    int cyc     = 0;
    int last_pulse = -1;

    vga_frame_reader #(
        .ACTIVE_COLUMNS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
        .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP),
        .CLK_DIV(DIV), .DATA_WIDTH(1), .SAND_RGB(SAND), .BG_RGB(BG)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .vram_rd_data_i(vram_rd_data_i),
        .vram_rd_address_o(vram_rd_address_o),
        .rgb_o(rgb_o),
        .hsync_o(hsync_o),
        .vsync_o(vsync_o),
        .vblank_o(vblank_o),
        .vblank_start_o(vblank_start_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) vram_rd_data_i <= mem[vram_rd_address_o];

    // Model: k clocks since reset release, t = k/DIV pixel ticks, position p = t mod FRAME
    function automatic int exp_addr(int t);
        int p, h, v;
        p = t % FRAME; h = p % HT; v = p / HT;
        if (p == 0) return 0;
        if (v < AR && h < AC) return v * AC + h;
        if (v < AR - 1) return (v + 1) * AC;
        return AC * AR - 1;
    endfunction

    function automatic int exp_rgb(int t);
        int p, h, v;
        if (t == 0) return 0;
        p = (t - 1) % FRAME; h = p % HT; v = p / HT;
        if (v < AR && h < AC) return mem[v * AC + h] ? int'(SAND) : int'(BG);
        return 0;
    endfunction

    function automatic int exp_hsync(int t);
        int h;
        if (t == 0) return 1;
        h = ((t - 1) % FRAME) % HT;
        return (h >= AC + HFP && h < AC + HFP + HSP) ? 0 : 1;
    endfunction

    function automatic int exp_vsync(int t);
        int v;
        if (t == 0) return 1;
        v = ((t - 1) % FRAME) / HT;
        return (v >= AR + VFP && v < AR + VFP + VSP) ? 0 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (clk %0d)", tag, obs, expv, k);
        end
    endtask

    task automatic check_outputs();
        int t;
        t = k / DIV;
        chk("addr",   32'(vram_rd_address_o), exp_addr(t));
        chk("rgb",    32'(rgb_o),   exp_rgb(t));
        chk("hsync",  32'(hsync_o), exp_hsync(t));
        chk("vsync",  32'(vsync_o), exp_vsync(t));
        chk("vblank", 32'(vblank_o), ((t % FRAME) / HT >= AR) ? 1 : 0);
        chk("vblank_start", 32'(vblank_start_o),
            (t >= 1 && k % DIV == 0 && t % FRAME == AR * HT) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk_i);
        if (!reset_i) k++;
        cyc++;
        @(negedge clk_i);
        check_outputs();
        if (vblank_start_o === 1'b1) begin
            if (last_pulse >= 0) chk("vblank_period", 32'(cyc - last_pulse), FRAME * DIV);
            last_pulse = cyc;
        end
    endtask

    task automatic async_reset(input int offset, input int hold, input bit randomize_mem);
        #(offset);
        reset_i    = 1'b1;
        k          = 0;
        last_pulse = -1;
        #1;
        check_outputs();
        if (randomize_mem) begin
            for (int i = 0; i < AC * AR; i++) mem[i] = bit'($urandom_range(0, 1));
        end
        repeat (hold) step();
        reset_i = 1'b0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < AC * AR; i++) mem[i] = 1'b0;
        mem[5] = 1'b1;
        #1 reset_i = 1'b1;
        repeat (3) step();
        reset_i = 1'b0;

        // Two full frames with a single sand cell at address 5
        repeat (2 * FRAME * DIV + 20) step();

        // Run to a mid-line position, then reset asynchronously between edges
        guard = 0;
        while (!((k / DIV) % FRAME == 3 * HT + 10 && k % DIV == 0) && guard < FRAME * DIV) begin
            step();
            guard++;
        end
        chk("reach_midline", 32'(guard < FRAME * DIV), 32'd1);
        async_reset(2, 3, 1'b1);
        repeat (2 * FRAME * DIV) step();

        // Random run lengths, reset offsets and hold times with fresh VRAM contents
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(50, FRAME * DIV)) step();
            async_reset($urandom_range(1, 4), $urandom_range(1, 3), 1'b1);
        end
        repeat (FRAME * DIV + 10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
